bsg_mem_banked_crossbar: RTL and testbench
==========================================

BSG_MEM_BANKED_CROSSBAR -- requirements
Module: bsg_mem_banked_crossbar

Interface
REQ-001 num_ports_p, default 2: number of requester ports (N).
REQ-002 num_banks_p, default 1: number of independent memory banks (B, power of 2).
REQ-003 bank_size_p, default 1024: words per bank.
REQ-004 data_width_p, default 32: word width (multiple of 8).
REQ-005 rr_lo_hi_p, default 0: per-bank arbitration mode; 0 = fixed priority with highest port index winning, 1 = fixed priority with lowest port index winning, 2 = round-robin.
REQ-006 Derived addr_width_lp = clog2(bank_size_p*num_banks_p); bank_addr_width_lp = clog2(bank_size_p).
REQ-007 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-008 reset_i  in  1  asynchronous, active-low reset.
REQ-009 reverse_pr_i  in  1  deprecated; ignored, tied to 0 by users.
REQ-010 v_i  in  N  per-port request valid.
REQ-011 w_i  in  N  per-port write (1) / read (0).
REQ-012 addr_i  in  N x addr_width_lp  per-port word address.
REQ-013 data_i  in  N x data_width_p  per-port write data.
REQ-014 mask_i  in  N x data_width_p/8  per-port byte write enables (bit k covers bits 8k+7:8k).
REQ-015 yumi_o  out  N  request accepted this cycle.
REQ-016 v_o  out  N  response valid (one per accepted request).
REQ-017 data_o  out  N x data_width_p  per-port read data.

Function
REQ-018 Bank select = addr_i low clog2(B) bits (none when B=1); in-bank word address = remaining upper bits.
REQ-019 Each bank is a 1RW synchronous RAM; at most one access per bank per cycle.
REQ-020 yumi_o[p] is combinational: 1 iff v_i[p]=1 and port p wins arbitration for its selected bank that cycle.
REQ-021 Ports targeting different banks are all granted in the same cycle.
REQ-022 Losing requester gets yumi_o=0 and must hold its request; no request is queued internally.
REQ-023 Round-robin mode: per-bank pointer; the granted port becomes lowest priority for the next arbitration of that bank; pointer advances only on a grant.
REQ-024 Granted write: bytes with mask bit 1 updated at the clock edge; bytes with mask 0 unchanged.
REQ-025 Granted read: data_o[p] shows the word exactly one cycle after the grant.
REQ-026 v_o[p] = registered yumi_o[p]: asserted exactly one cycle after every grant, reads and writes alike; single-cycle pulse per grant.
REQ-027 data_o[p] holds its last read value when no read of port p completes (including cycles after a write grant).
REQ-028 Read and write of the same address in the same cycle cannot occur (one access per bank).
REQ-029 Port p's response is never delayed or dropped; no backpressure exists on v_o/data_o.

Reset
REQ-030 While reset_i=0 (asynchronously): v_o=0, all round-robin pointers point to port 0, yumi_o is driven to 0.
REQ-031 RAM contents and data_o are not reset (undefined until written/read).
REQ-032 Reset asserted with a response pending: the pending v_o pulse is discarded; no response after reset release.

Verification (N=2, B=1, bank_size_p=16, data_width_p=32 unless stated)
REQ-033 Port1 write addr 3, data 0xDEADBEEF, mask 0xF -> yumi_o=2'b10 same cycle, v_o[1]=1 next cycle; then port0 read addr 3 -> v_o[0]=1 and data_o[0]=0xDEADBEEF one cycle after grant.
REQ-034 rr_lo_hi_p=0, both ports request same cycle -> yumi_o=2'b10; port0 holds request and gets yumi_o=2'b01 next cycle.
REQ-035 Over 0xDEADBEEF at addr 5, write 0x11223344 mask 4'b0101 -> read returns 0xDE22BE44.
REQ-036 B=2: port0 addr 0 (bank 0) and port1 addr 1 (bank 1) same cycle -> yumi_o=2'b11, both v_o next cycle.
REQ-037 rr_lo_hi_p=2, both ports request same bank continuously for 4 cycles -> grants alternate port0, port1, port0, port1.
REQ-038 Drive reset_i=0 in the cycle after a grant -> v_o=0 immediately, no v_o after release; mode 2 first grant after reset goes to port 0.

Source files
------------

// File: rtl/bsg_mem_banked_crossbar_if.sv
// rtl/bsg_mem_banked_crossbar_if.sv - requester-side bus of the banked crossbar memory
interface bsg_mem_banked_crossbar_if #(
    parameter int num_ports_p  = 2,
    parameter int num_banks_p  = 1,
    parameter int bank_size_p  = 1024,
    parameter int data_width_p = 32
);
    localparam int addr_width_lp = $clog2(bank_size_p * num_banks_p);

    logic [num_ports_p-1:0]                      v_i;
    logic [num_ports_p-1:0]                      w_i;
    logic [num_ports_p-1:0][addr_width_lp-1:0]   addr_i;
    logic [num_ports_p-1:0][data_width_p-1:0]    data_i;
    logic [num_ports_p-1:0][data_width_p/8-1:0]  mask_i;
    logic [num_ports_p-1:0]                      yumi_o;
    logic [num_ports_p-1:0]                      v_o;
    logic [num_ports_p-1:0][data_width_p-1:0]    data_o;

    modport master (
        output v_i, w_i, addr_i, data_i, mask_i,
        input  yumi_o, v_o, data_o
    );

    modport slave (
        input  v_i, w_i, addr_i, data_i, mask_i,
        output yumi_o, v_o, data_o
    );
endinterface

// File: rtl/bsg_mem_banked_crossbar.sv
// rtl/bsg_mem_banked_crossbar.sv - N-port crossbar onto B interleaved 1RW banks with per-bank arbitration
module bsg_mem_banked_crossbar #(
    parameter int num_ports_p  = 2,
    parameter int num_banks_p  = 1,
    parameter int bank_size_p  = 1024,
    parameter int data_width_p = 32,
    parameter int rr_lo_hi_p   = 0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic reverse_pr_i,
    bsg_mem_banked_crossbar_if.slave bus
);
    localparam int addr_width_lp = $clog2(bank_size_p * num_banks_p);
    localparam int lg_banks_lp   = $clog2(num_banks_p);
    localparam int bank_w_lp     = (num_banks_p > 1) ? lg_banks_lp : 1;
    localparam int ptr_w_lp      = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;
    localparam int bytes_lp      = data_width_p / 8;

    logic unused_reverse_pr;
    assign unused_reverse_pr = reverse_pr_i;

    logic [bank_w_lp-1:0]   bank_sel [num_ports_p];
    logic [ptr_w_lp-1:0]    rr_ptr_q [num_banks_p];
    logic [ptr_w_lp-1:0]    rr_ptr_n [num_banks_p];
    logic [num_ports_p-1:0] grant;
    logic [num_ports_p-1:0] yumi;
    logic [num_ports_p-1:0] v_q;
    logic [num_ports_p-1:0][data_width_p-1:0] data_q;
    logic [data_width_p-1:0] mem [bank_size_p * num_banks_p];

    // Banks are word-interleaved: the low address bits pick the bank.
    always_comb begin
        for (int p = 0; p < num_ports_p; p++) begin
            bank_sel[p] = bank_w_lp'(bus.addr_i[p] & addr_width_lp'(num_banks_p - 1));
        end
    end

    // rr_ptr_q holds the highest-priority port of each bank in round-robin mode.
    always_comb begin
        logic                found;
        logic [ptr_w_lp-1:0] pi;
        grant = '0;
        found = 1'b0;
        pi    = '0;
        for (int b = 0; b < num_banks_p; b++) begin
            rr_ptr_n[b] = rr_ptr_q[b];
            found       = 1'b0;
            for (int i = 0; i < num_ports_p; i++) begin
                if (rr_lo_hi_p == 0)
                    pi = ptr_w_lp'(num_ports_p - 1 - i);
                else if (rr_lo_hi_p == 1)
                    pi = ptr_w_lp'(i);
                else
                    pi = ptr_w_lp'((int'(rr_ptr_q[b]) + i) % num_ports_p);
                if (!found && bus.v_i[pi] && bank_sel[pi] == bank_w_lp'(b)) begin
                    grant[pi]   = 1'b1;
                    found       = 1'b1;
                    rr_ptr_n[b] = ptr_w_lp'((int'(pi) + 1) % num_ports_p);
                end
            end
        end
    end

    assign yumi = grant & {num_ports_p{reset_i}};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            v_q <= '0;
            for (int b = 0; b < num_banks_p; b++) rr_ptr_q[b] <= '0;
        end else begin
            v_q <= yumi;
            for (int b = 0; b < num_banks_p; b++) rr_ptr_q[b] <= rr_ptr_n[b];
        end
    end

    // Granted ports always target distinct banks, so their accesses never collide.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < num_ports_p; p++) begin
            if (yumi[p]) begin
                if (bus.w_i[p]) begin
                    for (int k = 0; k < bytes_lp; k++) begin
                        if (bus.mask_i[p][k])
                            mem[bus.addr_i[p]][8*k +: 8] <= bus.data_i[p][8*k +: 8];
                    end
                end else begin
                    data_q[p] <= mem[bus.addr_i[p]];
                end
            end
        end
    end

    assign bus.yumi_o = yumi;
    assign bus.v_o    = v_q;
    assign bus.data_o = data_q;
endmodule

// File: tb/tb_bsg_mem_banked_crossbar.sv
// tb/tb_bsg_mem_banked_crossbar.sv - directed self-checking bench for the banked crossbar
module tb_bsg_mem_banked_crossbar;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    bsg_mem_banked_crossbar_if #(.num_ports_p(2), .num_banks_p(1), .bank_size_p(16), .data_width_p(32)) bus0 ();
    bsg_mem_banked_crossbar_if #(.num_ports_p(2), .num_banks_p(1), .bank_size_p(16), .data_width_p(32)) bus2 ();
    bsg_mem_banked_crossbar_if #(.num_ports_p(2), .num_banks_p(2), .bank_size_p(16), .data_width_p(32)) busb ();

    bsg_mem_banked_crossbar #(.num_ports_p(2), .num_banks_p(1), .bank_size_p(16), .data_width_p(32), .rr_lo_hi_p(0))
        dut0 (.clk_i(clk), .reset_i(reset_n), .reverse_pr_i(1'b0), .bus(bus0));
    bsg_mem_banked_crossbar #(.num_ports_p(2), .num_banks_p(1), .bank_size_p(16), .data_width_p(32), .rr_lo_hi_p(2))
        dut2 (.clk_i(clk), .reset_i(reset_n), .reverse_pr_i(1'b0), .bus(bus2));
    bsg_mem_banked_crossbar #(.num_ports_p(2), .num_banks_p(2), .bank_size_p(16), .data_width_p(32), .rr_lo_hi_p(0))
        dutb (.clk_i(clk), .reset_i(reset_n), .reverse_pr_i(1'b0), .bus(busb));

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  w;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  m0;
        logic [3:0]  m1;
        logic [1:0]  yumi;
        logic [1:0]  rd;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.v_i = '0; bus0.w_i = '0; bus0.addr_i = '0; bus0.data_i = '0; bus0.mask_i = '0;
        bus2.v_i = '0; bus2.w_i = '0; bus2.addr_i = '0; bus2.data_i = '0; bus2.mask_i = '0;
        busb.v_i = '0; busb.w_i = '0; busb.addr_i = '0; busb.data_i = '0; busb.mask_i = '0;

        //              v      w      a0     a1     d0            d1            m0    m1    yumi   rd     e0            e1
        tbl[0]  = '{2'b10, 2'b10, 4'd0,  4'd3,  32'h0,        32'hDEADBEEF, 4'h0, 4'hF, 2'b10, 2'b00, 32'h0,        32'h0};
        tbl[1]  = '{2'b01, 2'b00, 4'd3,  4'd0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 32'h0};
        tbl[2]  = '{2'b10, 2'b10, 4'd0,  4'd5,  32'h0,        32'hDEADBEEF, 4'h0, 4'hF, 2'b10, 2'b00, 32'h0,        32'h0};
        tbl[3]  = '{2'b01, 2'b01, 4'd5,  4'd0,  32'h11223344, 32'h0,        4'h5, 4'h0, 2'b01, 2'b00, 32'h0,        32'h0};
        tbl[4]  = '{2'b10, 2'b00, 4'd0,  4'd5,  32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b10, 32'h0,        32'hDE22BE44};
        tbl[5]  = '{2'b11, 2'b00, 4'd3,  4'd5,  32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b10, 32'h0,        32'hDE22BE44};
        tbl[6]  = '{2'b01, 2'b00, 4'd3,  4'd5,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 32'h0};
        tbl[7]  = '{2'b01, 2'b01, 4'd3,  4'd0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 32'h0};
        tbl[8]  = '{2'b10, 2'b10, 4'd0,  4'd15, 32'h0,        32'hA5A5A5A5, 4'h0, 4'hF, 2'b10, 2'b10, 32'h0,        32'hDE22BE44};
        tbl[9]  = '{2'b10, 2'b00, 4'd0,  4'd15, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b10, 32'h0,        32'hA5A5A5A5};
        tbl[10] = '{2'b01, 2'b00, 4'd3,  4'd0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 32'h0};
        tbl[11] = '{2'b00, 2'b00, 4'd0,  4'd0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b11, 32'hDEADBEEF, 32'hA5A5A5A5};

        // Reset state: no grants even with requests present, no responses.
        bus0.v_i = 2'b11;
        #2;
        chk("reset yumi", 64'(bus0.yumi_o), 64'd0);
        chk("reset v_o", 64'(bus0.v_o), 64'd0);
        bus0.v_i = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            bus0.v_i      = tbl[i].v;
            bus0.w_i      = tbl[i].w;
            bus0.addr_i   = {tbl[i].a1, tbl[i].a0};
            bus0.data_i   = {tbl[i].d1, tbl[i].d0};
            bus0.mask_i   = {tbl[i].m1, tbl[i].m0};
            #4;
            chk($sformatf("vec%0d yumi", i), 64'(bus0.yumi_o), 64'(tbl[i].yumi));
            step();
            chk($sformatf("vec%0d v_o", i), 64'(bus0.v_o), 64'(tbl[i].yumi));
            if (tbl[i].rd[0]) chk($sformatf("vec%0d data0", i), 64'(bus0.data_o[0]), 64'(tbl[i].e0));
            if (tbl[i].rd[1]) chk($sformatf("vec%0d data1", i), 64'(bus0.data_o[1]), 64'(tbl[i].e1));
        end
        bus0.v_i = 2'b00;

        // Round-robin: continuous contention alternates starting at port 0.
        bus2.v_i = 2'b11;
        bus2.w_i = 2'b00;
        bus2.addr_i = '0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #4;
            chk($sformatf("rr%0d yumi", k), 64'(bus2.yumi_o), 64'(exp_g));
            step();
            chk($sformatf("rr%0d v_o", k), 64'(bus2.v_o), 64'(exp_g));
        end
        bus2.v_i = 2'b00;

        // Two banks: distinct banks both granted, same bank arbitrated.
        busb.v_i    = 2'b11;
        busb.w_i    = 2'b11;
        busb.addr_i = {5'd1, 5'd0};
        busb.data_i = {32'h22220001, 32'h11110000};
        busb.mask_i = {4'hF, 4'hF};
        #4;
        chk("bank wr yumi", 64'(busb.yumi_o), 64'd3);
        step();
        chk("bank wr v_o", 64'(busb.v_o), 64'd3);
        busb.w_i    = 2'b00;
        busb.addr_i = {5'd0, 5'd1};
        #4;
        chk("bank rd yumi", 64'(busb.yumi_o), 64'd3);
        step();
        chk("bank rd v_o", 64'(busb.v_o), 64'd3);
        chk("bank rd data0", 64'(busb.data_o[0]), 64'h22220001);
        chk("bank rd data1", 64'(busb.data_o[1]), 64'h11110000);
        busb.addr_i = {5'd4, 5'd2};
        #4;
        chk("same bank yumi", 64'(busb.yumi_o), 64'd2);
        step();
        chk("same bank v_o", 64'(busb.v_o), 64'd2);
        busb.v_i = 2'b00;

        // Reset with responses pending; round-robin pointer returns to port 0.
        bus0.v_i = 2'b10; bus0.w_i = 2'b00; bus0.addr_i = {4'd5, 4'd0};
        bus2.v_i = 2'b01; bus2.w_i = 2'b00; bus2.addr_i = '0;
        step();
        chk("pre-rst v_o0", 64'(bus0.v_o), 64'd2);
        chk("pre-rst v_o2", 64'(bus2.v_o), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst v_o0", 64'(bus0.v_o), 64'd0);
        chk("rst v_o2", 64'(bus2.v_o), 64'd0);
        bus2.v_i = 2'b11;
        #1;
        chk("rst yumi2", 64'(bus2.yumi_o), 64'd0);
        bus0.v_i = 2'b00;
        bus2.v_i = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post-rst v_o0", 64'(bus0.v_o), 64'd0);
        chk("post-rst v_o2", 64'(bus2.v_o), 64'd0);
        bus2.v_i = 2'b11;
        #4;
        chk("post-rst rr yumi", 64'(bus2.yumi_o), 64'd1);
        step();
        chk("post-rst rr v_o", 64'(bus2.v_o), 64'd1);
        bus2.v_i = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
